// File: rtl/ga_pkg.sv
// Shared GA pipeline constants, breed scheduler state encoding and operation codes.
package ga_pkg;

    localparam int POP     = 50;
    localparam int IDX_W   = 6;
    localparam int ELITE   = 10;
    localparam int PARENTS = 25;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ELITE = 2'd1,
        ST_BREED = 2'd2,
        ST_DONE  = 2'd3
    } breed_state_t;

    localparam logic OP_COPY  = 1'b0;
    localparam logic OP_BREED = 1'b1;

endpackage

// File: rtl/rank_mux.sv
// Combinational pick of one rank entry from the packed ranked-index vector.
module rank_mux #(
    parameter int POP   = 50,
    parameter int IDX_W = 6
) (
    input  logic [POP*IDX_W-1:0] i_vec,
    input  logic [IDX_W-1:0]     i_sel,
    output logic [IDX_W-1:0]     o_idx
);

    always_comb begin
        o_idx = '0;
        for (int r = 0; r < POP; r++) begin
            if (i_sel == IDX_W'(r)) begin
                o_idx = i_vec[IDX_W*r +: IDX_W];
            end
        end
    end

endmodule

// File: rtl/pop_breed_scheduler.sv
// Turns a latched ranked population into elite-copy then breed operations, one per accept.
// Registered outputs: op 0 one cycle after the start edge; fields hold while op_ready is low.
module pop_breed_scheduler #(
    parameter int POP     = ga_pkg::POP,
    parameter int IDX_W   = ga_pkg::IDX_W,
    parameter int ELITE   = ga_pkg::ELITE,
    parameter int PARENTS = ga_pkg::PARENTS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [POP*IDX_W-1:0] sorted,
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic                 op_breed,
    output logic [IDX_W-1:0]     op_a,
    output logic [IDX_W-1:0]     op_b,
    output logic [IDX_W-1:0]     op_dest,
    output logic                 done
);

    import ga_pkg::*;

    localparam logic [IDX_W-1:0] K_LAST_ELITE = IDX_W'(ELITE - 1);
    localparam logic [IDX_W-1:0] K_LAST       = IDX_W'(POP - 1);
    localparam logic [IDX_W-1:0] J_LAST       = IDX_W'(PARENTS - 1);

    breed_state_t           r_state;
    logic [POP*IDX_W-1:0]   r_rank;
    logic [IDX_W-1:0]       r_k;
    logic [IDX_W-1:0]       r_ja;
    logic [IDX_W-1:0]       r_jb;
    logic                   r_op_valid;
    logic                   r_op_breed;
    logic [IDX_W-1:0]       r_op_a;
    logic [IDX_W-1:0]       r_op_b;
    logic [IDX_W-1:0]       r_op_dest;
    logic                   r_done;

    breed_state_t           w_state_nxt;
    logic [POP*IDX_W-1:0]   w_rank_nxt;
    logic [IDX_W-1:0]       w_k_nxt;
    logic [IDX_W-1:0]       w_ja_nxt;
    logic [IDX_W-1:0]       w_jb_nxt;
    logic [IDX_W-1:0]       w_sel_a;
    logic [IDX_W-1:0]       w_mux_a;
    logic [IDX_W-1:0]       w_mux_b;
    logic                   w_accept;
    logic                   w_op_valid_nxt;
    logic                   w_op_breed_nxt;
    logic [IDX_W-1:0]       w_op_a_nxt;
    logic [IDX_W-1:0]       w_op_b_nxt;
    logic [IDX_W-1:0]       w_op_dest_nxt;
    logic                   w_done_nxt;

    assign w_accept = r_op_valid && op_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_rank_nxt  = r_rank;
        w_k_nxt     = r_k;
        w_ja_nxt    = r_ja;
        w_jb_nxt    = r_jb;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_rank_nxt  = sorted;
                    w_k_nxt     = '0;
                    w_ja_nxt    = '0;
                    w_jb_nxt    = IDX_W'(1);
                    w_state_nxt = ST_ELITE;
                end
            end
            ST_ELITE: begin
                if (w_accept) begin
                    w_k_nxt = r_k + IDX_W'(1);
                    if (r_k == K_LAST_ELITE) begin
                        w_state_nxt = ST_BREED;
                        w_ja_nxt    = '0;
                        w_jb_nxt    = IDX_W'(1);
                    end
                end
            end
            ST_BREED: begin
                if (w_accept) begin
                    if (r_k == K_LAST) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_k_nxt  = r_k + IDX_W'(1);
                        w_ja_nxt = (r_ja == J_LAST) ? '0 : r_ja + IDX_W'(1);
                        w_jb_nxt = (r_jb == J_LAST) ? '0 : r_jb + IDX_W'(1);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Muxes read the already-latched ranks; the first ELITE cycle is the load cycle with op_valid low.
    assign w_sel_a = (w_state_nxt == ST_BREED) ? w_ja_nxt : w_k_nxt;

    rank_mux #(.POP(POP), .IDX_W(IDX_W)) u_mux_a (
        .i_vec (r_rank),
        .i_sel (w_sel_a),
        .o_idx (w_mux_a)
    );

    rank_mux #(.POP(POP), .IDX_W(IDX_W)) u_mux_b (
        .i_vec (r_rank),
        .i_sel (w_jb_nxt),
        .o_idx (w_mux_b)
    );

    always_comb begin
        w_op_valid_nxt = 1'b0;
        w_op_breed_nxt = OP_COPY;
        w_op_a_nxt     = '0;
        w_op_b_nxt     = '0;
        w_op_dest_nxt  = '0;
        w_done_nxt     = 1'b0;
        case (w_state_nxt)
            ST_ELITE: begin
                if (r_state == ST_ELITE) begin
                    w_op_valid_nxt = 1'b1;
                    w_op_a_nxt     = w_mux_a;
                    w_op_dest_nxt  = w_k_nxt;
                end
            end
            ST_BREED: begin
                w_op_valid_nxt = 1'b1;
                w_op_breed_nxt = OP_BREED;
                w_op_a_nxt     = w_mux_a;
                w_op_b_nxt     = w_mux_b;
                w_op_dest_nxt  = w_k_nxt;
            end
            ST_DONE:  w_done_nxt = 1'b1;
            default:  w_done_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rank     <= '0;
            r_k        <= '0;
            r_ja       <= '0;
            r_jb       <= '0;
            r_op_valid <= 1'b0;
            r_op_breed <= OP_COPY;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_dest  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rank     <= w_rank_nxt;
            r_k        <= w_k_nxt;
            r_ja       <= w_ja_nxt;
            r_jb       <= w_jb_nxt;
            r_op_valid <= w_op_valid_nxt;
            r_op_breed <= w_op_breed_nxt;
            r_op_a     <= w_op_a_nxt;
            r_op_b     <= w_op_b_nxt;
            r_op_dest  <= w_op_dest_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign op_valid = r_op_valid;
    assign op_breed = r_op_breed;
    assign op_a     = r_op_a;
    assign op_b     = r_op_b;
    assign op_dest  = r_op_dest;
    assign done     = r_done;

endmodule

// File: tb/tb_pop_breed_scheduler.sv
// Directed bench for pop_breed_scheduler with a scoreboard of expected operations.
module tb_pop_breed_scheduler;

    import ga_pkg::*;

    localparam int W = POP * IDX_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [W-1:0]     sorted = '0;
    logic             op_ready = 1'b0;
    logic             op_valid;
    logic             op_breed;
    logic [IDX_W-1:0] op_a;
    logic [IDX_W-1:0] op_b;
    logic [IDX_W-1:0] op_dest;
    logic             done;

    typedef struct packed {
        logic             breed;
        logic [IDX_W-1:0] a;
        logic [IDX_W-1:0] b;
        logic [IDX_W-1:0] dest;
    } op_t;

    op_t exp_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    pop_breed_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sorted   (sorted),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_breed (op_breed),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_dest  (op_dest),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mk_vec(input int mode);
        logic [W-1:0] v;
        v = '0;
        for (int r = 0; r < POP; r++) begin
            case (mode)
                0:       v[IDX_W*r +: IDX_W] = IDX_W'(r);
                1:       v[IDX_W*r +: IDX_W] = IDX_W'(POP - 1 - r);
                default: v[IDX_W*r +: IDX_W] = IDX_W'($urandom_range(POP - 1, 0));
            endcase
        end
        return v;
    endfunction

    task automatic push_gen(input logic [W-1:0] v);
        op_t o;
        int  j;
        for (int k = 0; k < POP; k++) begin
            o.dest = IDX_W'(k);
            if (k < ELITE) begin
                o.breed = 1'b0;
                o.a     = v[IDX_W*k +: IDX_W];
                o.b     = '0;
            end else begin
                j       = k - ELITE;
                o.breed = 1'b1;
                o.a     = v[IDX_W*(j % PARENTS) +: IDX_W];
                o.b     = v[IDX_W*((j + 1) % PARENTS) +: IDX_W];
            end
            exp_q.push_back(o);
        end
    endtask

    // Pulses start for one edge, then checks the load cycle (no op yet, done low).
    task automatic do_start(input logic [W-1:0] v);
        @(negedge clk);
        sorted = v;
        start  = 1'b1;
        push_gen(v);
        @(negedge clk);
        start = 1'b0;
        chk("load_cycle", {30'd0, op_valid, done}, 32'd0);
    endtask

    task automatic drain(input int stall_at, input int stall_len, input int start_at,
                         input logic [W-1:0] alt, input int rst_at,
                         output int got, output int cycles);
        int   stalled;
        bit   rdy;
        bit   alt_sent;
        op_t  f;
        got      = 0;
        cycles   = 0;
        stalled  = 0;
        alt_sent = 0;
        while (got < POP && cycles < 400) begin
            @(negedge clk);
            cycles++;
            start = 1'b0;
            if (got == rst_at && op_valid) begin
                rst_n = 1'b0;
                #1;
                chk("reset_midrun", {30'd0, op_valid, done}, 32'd0);
                exp_q.delete();
                op_ready = 1'b0;
                return;
            end
            rdy = !(got == stall_at && stalled < stall_len);
            if (op_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_op", 32'd1, 32'd0);
                end else begin
                    f = exp_q[0];
                    chk($sformatf("op%0d", got),
                        {11'd0, op_valid, done, op_breed, op_a, op_b, op_dest},
                        {11'd0, 1'b1, 1'b0, f});
                    if (rdy) begin
                        void'(exp_q.pop_front());
                        got++;
                    end else begin
                        stalled++;
                    end
                end
            end
            if (got == start_at && !alt_sent) begin
                start    = 1'b1;
                sorted   = alt;
                alt_sent = 1;
            end
            op_ready = rdy;
        end
        if (got < POP) chk("drain_timeout", got, POP);
    endtask

    task automatic end_of_gen(input string tag);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done"}, {30'd0, op_valid, done}, 32'd1);
        chk({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        int got;
        int cyc;

        // Reset held: start toggling must have no effect.
        rst_n  = 1'b0;
        sorted = mk_vec(0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = ~start;
            chk("reset_outputs", {11'd0, op_valid, done, op_breed, op_a, op_b, op_dest}, 32'd0);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", {30'd0, op_valid, done}, 32'd0);

        // Identity ranking, always ready: 50 ops in 50 cycles, then done.
        do_start(mk_vec(0));
        drain(-1, 0, -1, '0, -1, got, cyc);
        chk("identity_count", got, POP);
        chk("identity_cycles", cyc, POP);
        end_of_gen("identity");

        // Reversed ranking, started from DONE, with a 3-cycle stall at op 10.
        do_start(mk_vec(1));
        drain(10, 3, -1, '0, -1, got, cyc);
        chk("reversed_count", got, POP);
        chk("reversed_cycles", cyc, POP + 3);
        end_of_gen("reversed");

        // Identity again; a start with a new vector during op 20 must be ignored.
        do_start(mk_vec(0));
        drain(10, 3, 20, mk_vec(2), -1, got, cyc);
        chk("ignore_start_count", got, POP);
        end_of_gen("ignore_start");

        // Random ranking, reset while op 20 is pending.
        do_start(mk_vec(2));
        drain(-1, 0, -1, '0, 20, got, cyc);
        chk("reset_at_op", got, 20);
        @(negedge clk);
        chk("reset_held", {30'd0, op_valid, done}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_midrun_reset", {30'd0, op_valid, done}, 32'd0);

        // Restart after reset begins at dest 0.
        do_start(mk_vec(2));
        drain(-1, 0, -1, '0, -1, got, cyc);
        chk("restart_count", got, POP);
        end_of_gen("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
